// File: rtl/icache_axi_refill_bridge_pkg.sv
// Shared AXI constants and bridge state encoding for the icache refill bridge.
package icache_axi_refill_bridge_pkg;

  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [2:0] SIZE_4B     = 3'd2;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    AR      = 3'd1,
    R       = 3'd2,
    RESP    = 3'd3,
    RELEASE = 3'd4
  } bridge_state_e;

endpackage

// File: rtl/icache_axi_refill_bridge_axi_beat_packer.sv
// Collects AXI R beats into one cacheline and accumulates burst error status.
module icache_axi_refill_bridge_axi_beat_packer
  import icache_axi_refill_bridge_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int LINE_W = 128
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              beat_valid,
  input  logic [DATA_W-1:0] beat_data,
  input  logic [1:0]        beat_resp,
  input  logic              beat_last,
  output logic [LINE_W-1:0] line,
  output logic              err,
  output logic              done
);

  localparam int BEATS = LINE_W / DATA_W;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  logic [CNT_W-1:0]  cnt_q;
  logic [LINE_W-1:0] line_q;
  logic              err_q;
  logic              last_slot;

  assign last_slot = (cnt_q == CNT_W'(BEATS - 1));
  // A burst ends on rlast or on the final slot; a disagreement between the two is an error.
  assign done      = beat_valid && (beat_last || last_slot);
  assign line      = line_q;
  assign err       = err_q;

  // NOTE: the line buffer is reset explicitly so data_o reads zero out of reset
  // and unfilled words of a short burst are deterministic.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      line_q <= '0;
      err_q  <= 1'b0;
    end else if (clear) begin
      cnt_q  <= '0;
      line_q <= '0;
      err_q  <= 1'b0;
    end else if (beat_valid) begin
      line_q[cnt_q*DATA_W +: DATA_W] <= beat_data;
      cnt_q                          <= cnt_q + 1'b1;
      if ((beat_resp != RESP_OKAY) || (beat_last != last_slot)) begin
        err_q <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/icache_axi_refill_bridge.sv
// Icache refill responder: one request -> one AXI4 INCR read burst -> one packed line pulse.
module icache_axi_refill_bridge
  import icache_axi_refill_bridge_pkg::*;
#(
  parameter int ADDR_WIDTH      = 32,
  parameter int CACHELINE_WIDTH = 128,
  parameter int AXI_DATA_WIDTH  = 32,
  parameter int ID_WIDTH        = 4,
  parameter int AXI_ID          = 0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       req_i,
  input  logic [ADDR_WIDTH-1:0]      addr_i,
  output logic                       rdy_o,
  output logic                       rvalid_o,
  output logic [1:0]                 rlast_o,
  output logic [CACHELINE_WIDTH-1:0] data_o,
  output logic [ID_WIDTH-1:0]        arid_o,
  output logic [ADDR_WIDTH-1:0]      araddr_o,
  output logic [7:0]                 arlen_o,
  output logic [2:0]                 arsize_o,
  output logic [1:0]                 arburst_o,
  output logic                       arvalid_o,
  input  logic                       arready_i,
  input  logic [ID_WIDTH-1:0]        rid_i,
  input  logic [AXI_DATA_WIDTH-1:0]  rdata_i,
  input  logic [1:0]                 rresp_i,
  input  logic                       rlast_i,
  input  logic                       rvalid_i,
  output logic                       rready_o
);

  localparam int BEATS = CACHELINE_WIDTH / AXI_DATA_WIDTH;

  bridge_state_e             state_q, state_d;
  logic [ADDR_WIDTH-1:0]     araddr_q;
  logic                      accept;
  logic                      beat_valid;
  logic                      beat_done;
  logic                      line_err;
  logic [CACHELINE_WIDTH-1:0] line;
  logic                      unused_ok;

  assign unused_ok = ^{rid_i, addr_i[3:0]};

  assign arid_o    = ID_WIDTH'(AXI_ID);
  assign arlen_o   = 8'(BEATS - 1);
  assign arsize_o  = SIZE_4B;
  assign arburst_o = BURST_INCR;

  assign accept     = (state_q == IDLE) && req_i;
  assign beat_valid = (state_q == R) && rvalid_i;

  icache_axi_refill_bridge_axi_beat_packer #(
    .DATA_W (AXI_DATA_WIDTH),
    .LINE_W (CACHELINE_WIDTH)
  ) u_packer (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (accept),
    .beat_valid (beat_valid),
    .beat_data  (rdata_i),
    .beat_resp  (rresp_i),
    .beat_last  (rlast_i),
    .line       (line),
    .err        (line_err),
    .done       (beat_done)
  );

  // NOTE: sequential state uses non-blocking assignments only; all combinational
  // decoding lives in the always_comb below.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      araddr_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        araddr_q <= {addr_i[ADDR_WIDTH-1:4], 4'b0000};
      end
    end
  end

  // NOTE: every output of this block gets a default first, so no latches are inferred.
  always_comb begin
    state_d   = state_q;
    rdy_o     = 1'b0;
    arvalid_o = 1'b0;
    rready_o  = 1'b0;
    rvalid_o  = 1'b0;
    rlast_o   = 2'b00;
    unique case (state_q)
      IDLE: begin
        rdy_o = req_i;
        if (req_i) state_d = AR;
      end
      AR: begin
        arvalid_o = 1'b1;
        if (arready_i) state_d = R;
      end
      R: begin
        rready_o = 1'b1;
        if (beat_done) state_d = RESP;
      end
      RESP: begin
        rvalid_o = 1'b1;
        rlast_o  = {line_err, 1'b1};
        state_d  = req_i ? RELEASE : IDLE;
      end
      RELEASE: begin
        if (!req_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign araddr_o = araddr_q;
  assign data_o   = line;

endmodule
